// File: rtl/dsp_arb_pkg.sv
// Shared definitions for the dual-DSP failover arbiter: FSM states and
// default timing constants for the 30 MHz board clock.
package dsp_arb_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_START  = 3'd0,
    ST_A      = 3'd1,
    ST_B      = 3'd2,
    ST_HOLD_A = 3'd3,
    ST_HOLD_B = 3'd4,
    ST_NONE   = 3'd5
  } state_t;

  localparam int CRAZY_TIME_DEFAULT = 45000;
  localparam int START_TIME_DEFAULT = 30000;
  localparam int HOLDOFF_DEFAULT    = 3000;

endpackage

// File: rtl/dsp_failover_arbiter_if.sv
// Heartbeat/force inputs and grant/status outputs of the failover arbiter.
interface dsp_failover_arbiter_if;
  import dsp_arb_pkg::*;

  logic               iHeartA;
  logic               iHeartB;
  logic               iForceA;
  logic               oGrantA;
  logic               oGrantB;
  logic               oFaultA;
  logic               oFaultB;
  logic [STATE_W-1:0] oState;
  logic [7:0]         oSwitchCnt;

  modport master (
    output iHeartA, iHeartB, iForceA,
    input  oGrantA, oGrantB, oFaultA, oFaultB, oState, oSwitchCnt
  );

  modport slave (
    input  iHeartA, iHeartB, iForceA,
    output oGrantA, oGrantB, oFaultA, oFaultB, oState, oSwitchCnt
  );

endinterface

// File: rtl/dsp_heartbeat_mon.sv
// Watches one DSP heartbeat: synchronizes it, times the gap since the last
// level change and flags a fault once the gap reaches CRAZY_TIME.
module dsp_heartbeat_mon
  import dsp_arb_pkg::*;
#(
  parameter int CRAZY_TIME = CRAZY_TIME_DEFAULT
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iHeart,
  input  logic iStartDone,
  output logic oFault
);

  localparam int CW = $clog2(CRAZY_TIME + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CRAZY_TIME);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] gap_cnt;
  logic          edge_seen;

  assign edge_seen = sync_q1 ^ sync_q2;

  // The gap counter parks at CNT_MAX, so the fault stays up until the next edge.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      gap_cnt <= '0;
      oFault  <= 1'b0;
    end else begin
      sync_q1 <= iHeart;
      sync_q2 <= sync_q1;
      if (edge_seen) begin
        gap_cnt <= '0;
        oFault  <= 1'b0;
      end else begin
        if (gap_cnt != CNT_MAX) gap_cnt <= gap_cnt + 1'b1;
        oFault <= (gap_cnt == CNT_MAX) && iStartDone;
      end
    end
  end

endmodule

// File: rtl/dsp_failover_arbiter.sv
// Grants the shared dual-port RAM to one healthy DSP and fails over to the
// other after a break-before-make dead time when the owner's heartbeat stops.
module dsp_failover_arbiter
  import dsp_arb_pkg::*;
#(
  parameter int CRAZY_TIME = CRAZY_TIME_DEFAULT,
  parameter int START_TIME = START_TIME_DEFAULT,
  parameter int HOLDOFF    = HOLDOFF_DEFAULT
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  dsp_failover_arbiter_if.slave  bus
);

  localparam int SW = $clog2(START_TIME + 1);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [SW-1:0] START_MAX  = SW'(START_TIME);
  localparam logic [SW-1:0] START_PREV = SW'(START_TIME - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF - 1);

  state_t        state;
  state_t        next_state;
  logic [SW-1:0] start_cnt;
  logic          start_done;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;
  logic          in_hold;
  logic          switch_done;
  logic          fault_a;
  logic          fault_b;
  logic          grant_a;
  logic          grant_b;
  logic [7:0]    switch_cnt;

  assign start_done = (start_cnt == START_MAX);
  assign in_hold    = (state == ST_HOLD_A) || (state == ST_HOLD_B);

  dsp_heartbeat_mon #(.CRAZY_TIME(CRAZY_TIME)) u_mon_a (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iHeart     (bus.iHeartA),
    .iStartDone (start_done),
    .oFault     (fault_a)
  );

  dsp_heartbeat_mon #(.CRAZY_TIME(CRAZY_TIME)) u_mon_b (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iHeart     (bus.iHeartB),
    .iStartDone (start_done),
    .oFault     (fault_b)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      start_cnt <= '0;
    end else if (!start_done) begin
      start_cnt <= start_cnt + 1'b1;
    end
  end

  // hold_done lands one cycle after the count tops out, giving HOLDOFF+1 dead cycles.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      hold_cnt  <= '0;
      hold_done <= 1'b0;
    end else if (in_hold) begin
      if (hold_cnt == HOLD_LAST) hold_done <= 1'b1;
      else                       hold_cnt  <= hold_cnt + 1'b1;
    end else begin
      hold_cnt  <= '0;
      hold_done <= 1'b0;
    end
  end

  always_comb begin
    next_state  = state;
    switch_done = 1'b0;
    case (state)
      ST_START:
        if (start_cnt == START_PREV) next_state = ST_A;
      ST_A:
        if (fault_a && fault_b) next_state = ST_NONE;
        else if (fault_a)       next_state = ST_HOLD_B;
      ST_B:
        if (fault_b && fault_a)           next_state = ST_NONE;
        else if (fault_b)                 next_state = ST_HOLD_A;
        else if (bus.iForceA && !fault_a) next_state = ST_HOLD_A;
      ST_HOLD_A:
        if (hold_done) begin
          if (fault_a) begin
            next_state = ST_NONE;
          end else begin
            next_state  = ST_A;
            switch_done = 1'b1;
          end
        end
      ST_HOLD_B:
        if (hold_done) begin
          if (fault_b) begin
            next_state = ST_NONE;
          end else begin
            next_state  = ST_B;
            switch_done = 1'b1;
          end
        end
      ST_NONE:
        if (!fault_a)      next_state = ST_HOLD_A;
        else if (!fault_b) next_state = ST_HOLD_B;
      default:
        next_state = ST_START;
    endcase
  end

  // Grants are decoded from the single next state, so they can never overlap.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= ST_START;
      grant_a    <= 1'b0;
      grant_b    <= 1'b0;
      switch_cnt <= '0;
    end else begin
      state   <= next_state;
      grant_a <= (next_state == ST_A);
      grant_b <= (next_state == ST_B);
      if (switch_done && (switch_cnt != 8'hFF)) switch_cnt <= switch_cnt + 1'b1;
    end
  end

  assign bus.oGrantA    = grant_a;
  assign bus.oGrantB    = grant_b;
  assign bus.oFaultA    = fault_a;
  assign bus.oFaultB    = fault_b;
  assign bus.oState     = state;
  assign bus.oSwitchCnt = switch_cnt;

endmodule

// File: tb/tb_dsp_failover_arbiter.sv
// Bench for dsp_failover_arbiter: directed failover scenarios plus random
// heartbeat dropouts, checked every cycle against a timestamp-based model.
module tb_dsp_failover_arbiter;

  localparam int C = 20;
  localparam int S = 10;
  localparam int H = 5;

  logic clk;
  logic rst_n;

  dsp_failover_arbiter_if bus ();

  dsp_failover_arbiter #(
    .CRAZY_TIME (C),
    .START_TIME (S),
    .HOLDOFF    (H)
  ) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
  );

  int compared = 0;
  int mismatched = 0;

  bit run_a = 0;
  bit run_b = 0;
  int phase = 0;
  int last_samp_a = 0;

  int cyc = 0;
  int m_mode = 0;
  bit m_fa = 0;
  bit m_fb = 0;
  int m_sw = 0;
  int hold_end = 0;
  int last_chg_a = -1;
  int last_chg_b = -1;
  bit lvl_a = 0;
  bit lvl_b = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, actual, expected, cyc, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Heartbeats toggle every 8 clocks on a shared phase, so restarts line up.
  initial begin
    bus.iHeartA = 1'b0;
    bus.iHeartB = 1'b0;
    forever begin
      tick();
      phase++;
      if (phase % 8 == 0) begin
        if (run_a) begin
          bus.iHeartA = ~bus.iHeartA;
          last_samp_a = cyc + 1;
        end
        if (run_b) bus.iHeartB = ~bus.iHeartB;
      end
    end
  end

  task automatic modelReset();
    cyc = 0;
    m_mode = 0;
    m_fa = 0;
    m_fb = 0;
    m_sw = 0;
    hold_end = 0;
    last_chg_a = -1;
    last_chg_b = -1;
    lvl_a = 0;
    lvl_b = 0;
  endtask

  task automatic beginHold(input int target);
    m_mode = (target == 1) ? 3 : 4;
    hold_end = cyc + H + 1;
  endtask

  // One model step per rising edge; faults from the previous edge drive decisions.
  task automatic modelStep();
    bit fa, fb, tf;
    int target;
    if (!rst_n) begin
      modelReset();
      return;
    end
    cyc++;
    fa = m_fa;
    fb = m_fb;
    case (m_mode)
      0: if (cyc == S) m_mode = 1;
      1: if (fa && fb) m_mode = 5; else if (fa) beginHold(2);
      2: if (fa && fb) m_mode = 5; else if (fb) beginHold(1); else if (bus.iForceA && !fa) beginHold(1);
      3, 4: if (cyc == hold_end) begin
        target = (m_mode == 3) ? 1 : 2;
        tf = (target == 1) ? fa : fb;
        if (tf) m_mode = 5;
        else begin
          m_mode = target;
          if (m_sw < 255) m_sw++;
        end
      end
      5: if (!fa) beginHold(1); else if (!fb) beginHold(2);
      default: m_mode = 0;
    endcase
    m_fa = (cyc - last_chg_a >= C + 2) && (cyc - 1 >= S);
    m_fb = (cyc - last_chg_b >= C + 2) && (cyc - 1 >= S);
    if (bus.iHeartA != lvl_a) begin
      lvl_a = bus.iHeartA;
      last_chg_a = cyc;
    end
    if (bus.iHeartB != lvl_b) begin
      lvl_b = bus.iHeartB;
      last_chg_b = cyc;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  // Per-cycle comparison against the model, plus exclusivity and dead-time checks.
  initial begin
    bit prev_any, cur_any, first_grant;
    int idle;
    prev_any = 0;
    first_grant = 1;
    idle = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("rst_grantA", bus.oGrantA, 0);
        checkOutput("rst_grantB", bus.oGrantB, 0);
        checkOutput("rst_state", bus.oState, 0);
        checkOutput("rst_switch", bus.oSwitchCnt, 0);
        first_grant = 1;
        prev_any = 0;
        idle = 0;
      end else begin
        checkOutput("state", bus.oState, m_mode);
        checkOutput("grantA", bus.oGrantA, (m_mode == 1) ? 1 : 0);
        checkOutput("grantB", bus.oGrantB, (m_mode == 2) ? 1 : 0);
        checkOutput("faultA", bus.oFaultA, m_fa);
        checkOutput("faultB", bus.oFaultB, m_fb);
        checkOutput("switchCnt", bus.oSwitchCnt, m_sw);
        checkOutput("grant_exclusive", (bus.oGrantA && bus.oGrantB) ? 1 : 0, 0);
        cur_any = bus.oGrantA || bus.oGrantB;
        if (cur_any && !prev_any) begin
          if (!first_grant) checkOutput("dead_time_ok", (idle >= H + 1) ? 1 : 0, 1);
          first_grant = 0;
        end
        idle = cur_any ? 0 : idle + 1;
        prev_any = cur_any;
      end
    end
  end

  function automatic int probe(input int sel);
    case (sel)
      0: return int'(bus.oState);
      1: return int'(bus.oGrantA);
      2: return int'(bus.oGrantB);
      3: return int'(bus.oFaultA);
      default: return -1;
    endcase
  endfunction

  task automatic waitFor(input string name, input int sel, input int value, input int limit);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (probe(sel) != value && g < limit);
    checkOutput({name, "_reached"}, probe(sel), value);
  endtask

  task automatic waitUntilCyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit a, input bit b, input bit force_pulse, input int cycles);
    run_a = a;
    run_b = b;
    if (force_pulse) begin
      tick();
      bus.iForceA = 1'b1;
      tick();
      bus.iForceA = 1'b0;
    end
    repeat (cycles) tick();
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int mark;
    rst_n = 1'b0;
    bus.iForceA = 1'b0;
    repeat (3) tick();

    $display("[TB] power-up with both hearts toggling");
    run_a = 1;
    run_b = 1;
    rst_n = 1'b1;
    waitUntilCyc(S - 1);
    checkOutput("startup_state_early", bus.oState, 0);
    checkOutput("startup_grantA_early", bus.oGrantA, 0);
    waitUntilCyc(S);
    checkOutput("startup_state_a", bus.oState, 1);
    checkOutput("startup_grantA", bus.oGrantA, 1);
    applyStimulus(1, 1, 0, 60);
    checkOutput("healthy_faultA", bus.oFaultA, 0);
    checkOutput("healthy_faultB", bus.oFaultB, 0);
    checkOutput("healthy_switch", bus.oSwitchCnt, 0);

    $display("[TB] force pulse in ST_A is dropped");
    applyStimulus(1, 1, 1, 5);
    checkOutput("forceA_ignored_state", bus.oState, 1);

    $display("[TB] A stops, B keeps toggling");
    applyStimulus(0, 1, 0, 0);
    waitFor("faultA_rise", 3, 1, 200);
    checkOutput("faultA_latency", cyc - last_samp_a, C + 2);
    @(negedge clk);
    checkOutput("failover_grantA_drop", bus.oGrantA, 0);
    checkOutput("failover_state_holdB", bus.oState, 4);
    mark = cyc;
    waitFor("grantB_rise", 2, 1, 50);
    checkOutput("grantB_delay", cyc - mark, H + 1);
    checkOutput("switch_after_failover", bus.oSwitchCnt, 1);

    $display("[TB] A resumes, B stays owner until forced");
    applyStimulus(1, 1, 0, 80);
    checkOutput("nonrevertive_state", bus.oState, 2);
    checkOutput("recovered_faultA", bus.oFaultA, 0);
    applyStimulus(1, 1, 1, 0);
    @(negedge clk);
    checkOutput("force_state_holdA", bus.oState, 3);
    mark = cyc;
    waitFor("force_back_to_a", 0, 1, 50);
    checkOutput("force_delay", cyc - mark, H + 1);
    checkOutput("switch_after_force", bus.oSwitchCnt, 2);

    $display("[TB] both hearts stop, then restart together");
    applyStimulus(0, 0, 0, 0);
    waitFor("both_dead_none", 0, 5, 200);
    checkOutput("none_grantA", bus.oGrantA, 0);
    checkOutput("none_grantB", bus.oGrantB, 0);
    applyStimulus(1, 1, 0, 0);
    waitFor("restart_holdA", 0, 3, 50);
    waitFor("restart_state_a", 0, 1, 50);
    checkOutput("switch_after_restart", bus.oSwitchCnt, 3);

    $display("[TB] reset in the middle of ST_HOLD_B");
    applyStimulus(1, 1, 0, 40);
    applyStimulus(0, 1, 0, 0);
    waitFor("reset_holdB", 0, 4, 200);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_state", bus.oState, 0);
    checkOutput("async_rst_switch", bus.oSwitchCnt, 0);
    checkOutput("async_rst_grantA", bus.oGrantA, 0);
    checkOutput("async_rst_grantB", bus.oGrantB, 0);
    repeat (3) tick();
    run_a = 1;
    rst_n = 1'b1;
    waitUntilCyc(S - 1);
    checkOutput("restart_state_early", bus.oState, 0);
    waitUntilCyc(S);
    checkOutput("restart_grantA", bus.oGrantA, 1);
    checkOutput("restart_switch", bus.oSwitchCnt, 0);

    $display("[TB] random heartbeat dropouts");
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, $urandom_range(60, 500));
    end
    applyStimulus(1, 1, 0, 100);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
